ifu: RTL and testbench
======================

# ifu

Instruction fetch unit for the MIPS core: holds the architectural PC, fetches each instruction from instruction memory over a valid/ready handshake, and presents `pc`/`instr` to decode and to `NPC`. It consumes `NPC`'s next-PC result (`next_pc`) and sits directly upstream of it. It also supports downstream stall and, optionally, flags illegal fetch addresses.

## Interface
- `PC_RESET`, 32'h0000_3000, PC value after reset.
- `IM_BASE`, 32'h0000_3000, first byte address of instruction memory.
- `IM_WORDS`, 4096, instruction memory size in 32-bit words.

- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: asynchronous, active-high.
- `next_pc` in 32: next PC from `NPC`, sampled only on HOLD→REQ transition.
- `stall` in 1: downstream cannot accept the held instruction.
- `im_req` out 1: fetch request valid.
- `im_addr` out 32: byte address of fetch, equals `pc` while `im_req`.
- `im_ready` in 1: memory returns `im_rdata` this cycle (may be same cycle as request).
- `im_rdata` in 32: fetched word.
- `pc` out 32: PC of current/held instruction.
- `instr` out 32: registered instruction word.
- `instr_valid` out 1: `instr` is valid for the current `pc`.
- `fetch_err` out 1: sticky illegal-fetch flag (see Configuration).

## Operation
- States: IDLE, REQ, HOLD, ERR (ERR only with macro).
- IDLE: entered on reset; `im_req`=0; unconditionally → REQ next cycle.
- REQ: `im_req`=1, `im_addr`=`pc`, both stable until `im_ready`. On `im_ready`: `instr`<=`im_rdata`, → HOLD. `stall` ignored in REQ.
- HOLD: `instr_valid`=1. If `stall`=1: stay, `pc`/`instr` frozen. If `stall`=0: `pc`<=`next_pc`, `instr_valid` drops, → REQ (or ERR if checked address illegal).
- `im_ready` outside REQ is ignored.
- `pc` only changes in HOLD with `stall`=0; no arithmetic done here (`NPC` computes PC+4/branch/jump).
- Reset values: `pc`=`PC_RESET`, `instr`=0, `instr_valid`=0, `im_req`=0, `fetch_err`=0, state=IDLE.
- Reset mid-REQ abandons the request; memory must tolerate a dropped request.

## Timing
- `im_req`, `im_addr`, `instr_valid` are decoded from registered state/`pc` (no combinational path from inputs).
- With same-cycle `im_ready`: REQ 1 cycle + HOLD 1 cycle → peak throughput 1 instruction / 2 cycles.
- Each extra memory wait cycle adds 1 cycle in REQ; each `stall` cycle adds 1 cycle in HOLD.
- First `im_req` asserts in the 2nd cycle after `reset` deasserts (IDLE then REQ).
- `next_pc` must be valid in HOLD; it may depend combinationally on `pc` and `instr`.

## Configuration
- `IFU_ALIGN_CHECK_EN` defined: on HOLD→REQ, if `next_pc[1:0]`≠0 or `next_pc` outside [`IM_BASE`, `IM_BASE`+4·`IM_WORDS`), `pc`<=`next_pc`, → ERR instead of REQ. ERR: `im_req`=0, `instr_valid`=0, `instr`=0, `fetch_err`=1; only `reset` exits. Same check applies to `PC_RESET` leaving IDLE.
- Not defined: no range check, no ERR state; `im_addr` = {`pc`[31:2],2'b00}; `fetch_err` tied 0.

## Structure
- State encodings (`IFU_S_IDLE`, `IFU_S_REQ`, `IFU_S_HOLD`, `IFU_S_ERR`) and default `PC_RESET`/`IM_BASE` go in shared `const.v` beside the `JumpOp` constants.
- One combinational sub-module `ifu_addr_chk` (address in, legal bit out), instantiated only under `IFU_ALIGN_CHECK_EN`.

## Test plan
- Reset, `im_ready` tied 1, `next_pc`=`pc`+4 → `pc` sequence 0x3000, 0x3004, 0x3008; `instr_valid` high every other cycle; first `im_req` 2 cycles after reset release.
- `im_ready` held low 3 cycles in REQ → `im_addr`=0x3000 stable for 4 cycles, `instr` captured on the 4th, HOLD follows.
- `stall`=1 for 5 cycles in HOLD with `next_pc` toggling → `pc`/`instr` unchanged, `instr_valid`=1 throughout; advance on first cycle `stall`=0.
- `next_pc`=0x0000_3002 with macro → ERR, `fetch_err`=1, `im_req`=0 until reset; without macro → `im_addr`=0x3000.
- `next_pc`=0x0000_7000 (`IM_WORDS`=4096) with macro → ERR; 0x0000_6FFC → normal fetch.
- `reset` asserted mid-REQ with `im_ready`=0 → immediate `pc`=0x3000, `im_req`=0, `instr_valid`=0, `fetch_err`=0.

Source files
------------

// File: rtl/ifu_pkg.sv
// Shared fetch-unit definitions: FSM state encoding, default fetch addresses
// and instruction-memory geometry, plus a word-alignment helper.
package ifu_pkg;

  localparam logic [31:0] IFU_PC_RESET = 32'h0000_3000;
  localparam logic [31:0] IFU_IM_BASE  = 32'h0000_3000;
  localparam int unsigned IFU_IM_WORDS = 4096;

  typedef enum logic [1:0] {
    IFU_S_IDLE = 2'd0,
    IFU_S_REQ  = 2'd1,
    IFU_S_HOLD = 2'd2,
    IFU_S_ERR  = 2'd3
  } ifu_state_e;

  // Word-aligned view of a byte address.
  function automatic logic [31:0] ifu_word_addr(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_addr_chk.sv
// Fetch-address legality check: word aligned and inside instruction memory.
// Only instantiated when IFU_ALIGN_CHECK_EN is defined.
module ifu_addr_chk
  import ifu_pkg::*;
#(
  parameter logic [31:0] IM_BASE  = IFU_IM_BASE,
  parameter int unsigned IM_WORDS = IFU_IM_WORDS
) (
  input  logic [31:0] addr_i,
  output logic        legal_o
);

  // One past the last legal byte, widened so the bound cannot wrap.
  localparam logic [32:0] IM_LIMIT = {1'b0, IM_BASE} + (33'(IM_WORDS) * 33'd4);

  // Alignment plus half-open range test.
  always_comb begin
    legal_o = (addr_i[1:0] == 2'b00) &&
              (addr_i >= IM_BASE) &&
              ({1'b0, addr_i} < IM_LIMIT);
  end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: holds the architectural PC, fetches one word per
// instruction over a valid/ready handshake and holds it for decode/NPC until
// downstream releases the stall.
// Optional feature macro: IFU_ALIGN_CHECK_EN (illegal next-PC -> sticky ERR).
module ifu
  import ifu_pkg::*;
#(
  parameter logic [31:0] PC_RESET = IFU_PC_RESET
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] next_pc,
  input  logic        stall,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ready,
  input  logic [31:0] im_rdata,
  output logic [31:0] pc,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        fetch_err
);

  ifu_state_e  state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        addr_ok;

`ifdef IFU_ALIGN_CHECK_EN
  logic [31:0] chk_addr;

  // IDLE validates the reset PC; HOLD validates the incoming next PC.
  always_comb begin
    chk_addr = (state_q == IFU_S_IDLE) ? pc_q : next_pc;
  end

  ifu_addr_chk u_addr_chk (
    .addr_i  (chk_addr),
    .legal_o (addr_ok)
  );
`else
  assign addr_ok = 1'b1;
`endif

  // Fetch FSM with PC and instruction registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IFU_S_IDLE;
      pc_q    <= PC_RESET;
      instr_q <= '0;
    end else begin
      case (state_q)
        IFU_S_IDLE: state_q <= addr_ok ? IFU_S_REQ : IFU_S_ERR;
        IFU_S_REQ: begin
          if (im_ready) begin
            instr_q <= im_rdata;
            state_q <= IFU_S_HOLD;
          end
        end
        IFU_S_HOLD: begin
          if (!stall) begin
            pc_q <= next_pc;
            if (addr_ok) begin
              state_q <= IFU_S_REQ;
            end else begin
              state_q <= IFU_S_ERR;
              instr_q <= '0;
            end
          end
        end
        default: state_q <= IFU_S_ERR;
      endcase
    end
  end

  // Outputs decoded purely from registered state and PC.
  always_comb begin
    im_req      = (state_q == IFU_S_REQ);
    instr_valid = (state_q == IFU_S_HOLD);
    pc          = pc_q;
    instr       = instr_q;
`ifdef IFU_ALIGN_CHECK_EN
    im_addr     = pc_q;
    fetch_err   = (state_q == IFU_S_ERR);
`else
    im_addr     = ifu_word_addr(pc_q);
    fetch_err   = 1'b0;
`endif
  end

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: directed handshake/stall/reset scenarios,
// then a randomized run whose expected fetch stream comes from a scoreboard.
module tb_ifu;

  localparam logic [31:0] PC_RST = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, stall, im_ready, im_req, instr_valid, fetch_err;
  logic [31:0] next_pc, im_addr, im_rdata, pc, instr;

  int unsigned checks = 0;
  int unsigned errors = 0;

  exp_t        sb[$];
  bit          mon_en = 1'b0;
  logic        prev_iv = 1'b0;
  logic [31:0] held_pc, held_ins;

  ifu dut (
    .clk         (clk),
    .reset       (reset),
    .next_pc     (next_pc),
    .stall       (stall),
    .im_req      (im_req),
    .im_addr     (im_addr),
    .im_ready    (im_ready),
    .im_rdata    (im_rdata),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .fetch_err   (fetch_err)
  );

  always #5 clk = ~clk;

  // Contents of instruction memory as a function of word address.
  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Assumes current negedge is in REQ; completes the fetch, returns in HOLD.
  task automatic fetch_one(input logic [31:0] data);
    im_ready = 1'b1;
    im_rdata = data;
    @(negedge clk);
    im_ready = 1'b0;
    im_rdata = $urandom();
  endtask

  // Reset pulse; returns at the first negedge with the FSM in REQ.
  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
  endtask

  // Scoreboard monitor: pops an expected fetch whenever a new instruction is
  // presented, and checks that a held instruction stays frozen.
  always @(negedge clk) begin
    if (mon_en) begin
      if (instr_valid && !prev_iv) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow actual=unexpected_fetch required=none pc=%h", pc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("fetch_pc", pc, e.pc);
          chk("fetch_instr", instr, e.ins);
          held_pc  = e.pc;
          held_ins = e.ins;
        end
      end else if (instr_valid) begin
        chk("hold_pc", pc, held_pc);
        chk("hold_instr", instr, held_ins);
      end
      if (im_req && sb.size() != 0) begin
        chk("req_addr", im_addr, {sb[0].pc[31:2], 2'b00});
      end
    end
    prev_iv = instr_valid;
  end

  initial begin
    logic [31:0] tgt[$];
    logic [31:0] prev, t;
    int unsigned k, cyc;
    exp_t e;
    localparam int unsigned NFETCH = 200;

    reset = 1'b1; stall = 1'b0; im_ready = 1'b0; next_pc = '0; im_rdata = '0;
    repeat (2) @(negedge clk);

    // Reset values.
    chk("rst_pc", pc, PC_RST);
    chk("rst_instr", instr, 32'h0);
    chk("rst_valid", {31'b0, instr_valid}, 32'h0);
    chk("rst_req", {31'b0, im_req}, 32'h0);
    chk("rst_err", {31'b0, fetch_err}, 32'h0);

    // First request appears in the second cycle after release.
    reset = 1'b0;
    #1 chk("idle_req", {31'b0, im_req}, 32'h0);
    @(negedge clk);

    // Memory wait: three not-ready cycles then ready; address stays put.
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      chk("wait_req", {31'b0, im_req}, 32'h1);
      chk("wait_addr", im_addr, PC_RST);
      chk("wait_valid", {31'b0, instr_valid}, 32'h0);
      stall    = $urandom_range(0, 1);
      im_ready = (i == 3);
      im_rdata = (i == 3) ? 32'hDEAD_BEEF : $urandom();
    end
    @(negedge clk);
    im_ready = 1'b0;

    // Five stall cycles with a noisy next_pc, then release to 0x3002.
    for (int i = 0; i < 6; i++) begin
      chk("stall_valid", {31'b0, instr_valid}, 32'h1);
      chk("stall_pc", pc, PC_RST);
      chk("stall_instr", instr, 32'hDEAD_BEEF);
      chk("stall_req", {31'b0, im_req}, 32'h0);
      stall    = (i < 5);
      next_pc  = (i < 5) ? $urandom() : 32'h0000_3002;
      im_ready = $urandom_range(0, 1);
      im_rdata = $urandom();
      @(negedge clk);
    end
    stall = 1'b0; im_ready = 1'b0;

`ifdef IFU_ALIGN_CHECK_EN
    // Misaligned next PC traps into a sticky error.
    for (int i = 0; i < 4; i++) begin
      chk("err_flag", {31'b0, fetch_err}, 32'h1);
      chk("err_req", {31'b0, im_req}, 32'h0);
      chk("err_valid", {31'b0, instr_valid}, 32'h0);
      chk("err_instr", instr, 32'h0);
      chk("err_pc", pc, 32'h0000_3002);
      im_ready = $urandom_range(0, 1);
      stall    = $urandom_range(0, 1);
      next_pc  = PC_RST;
      @(negedge clk);
    end
    stall = 1'b0; im_ready = 1'b0;

    // One word past the end of memory is illegal.
    do_reset();
    chk("err_cleared", {31'b0, fetch_err}, 32'h0);
    fetch_one(32'h1111_1111);
    next_pc = 32'h0000_7000;
    @(negedge clk);
    chk("range_err", {31'b0, fetch_err}, 32'h1);
    chk("range_req", {31'b0, im_req}, 32'h0);

    // Last word of memory is legal.
    do_reset();
    fetch_one(32'h2222_2222);
    next_pc = 32'h0000_6FFC;
    @(negedge clk);
    chk("last_req", {31'b0, im_req}, 32'h1);
    chk("last_addr", im_addr, 32'h0000_6FFC);
    chk("last_err", {31'b0, fetch_err}, 32'h0);
`else
    // Without the check a misaligned PC fetches the enclosing word.
    chk("mis_req", {31'b0, im_req}, 32'h1);
    chk("mis_addr", im_addr, 32'h0000_3000);
    chk("mis_pc", pc, 32'h0000_3002);
    chk("mis_err", {31'b0, fetch_err}, 32'h0);
    fetch_one(32'h1111_1111);
    chk("mis_instr", instr, 32'h1111_1111);
    next_pc = 32'h0000_6FFC;
    @(negedge clk);
    chk("last_addr", im_addr, 32'h0000_6FFC);
    fetch_one(32'h2222_2222);
    next_pc = 32'h0000_7000;
    @(negedge clk);
    chk("norange_req", {31'b0, im_req}, 32'h1);
    chk("norange_addr", im_addr, 32'h0000_7000);
    chk("norange_err", {31'b0, fetch_err}, 32'h0);
`endif

    // Asynchronous reset in the middle of an unanswered request.
    im_ready = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("areset_pc", pc, PC_RST);
    chk("areset_req", {31'b0, im_req}, 32'h0);
    chk("areset_valid", {31'b0, instr_valid}, 32'h0);
    chk("areset_err", {31'b0, fetch_err}, 32'h0);
    @(negedge clk);

    // Randomized run: precompute the target PC stream and expected fetches.
    prev = PC_RST;
    e.pc = PC_RST; e.ins = memfn(PC_RST);
    sb.push_back(e);
    for (int i = 0; i < int'(NFETCH); i++) begin
      if ($urandom_range(0, 3) != 0) t = prev + 32'd4;
      else t = 32'h0000_3000 + (32'($urandom_range(0, 4095)) << 2);
      if (t >= 32'h0000_7000) t = 32'h0000_3000;
      tgt.push_back(t);
      e.pc = t; e.ins = memfn(t);
      sb.push_back(e);
      prev = t;
    end

    reset = 1'b0;
    mon_en = 1'b1;
    k = 0; cyc = 0;
    while (sb.size() != 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      im_ready = ($urandom_range(0, 2) != 0);
      im_rdata = im_ready ? memfn({im_addr[31:2], 2'b00}) : $urandom();
      if (instr_valid) stall = (k >= NFETCH) ? 1'b1 : ($urandom_range(0, 3) == 0);
      else stall = $urandom_range(0, 1);
      next_pc = (instr_valid && !stall) ? tgt[k] : $urandom();
      if (instr_valid && !stall) k++;
    end
    chk("random_in_time", {31'b0, (cyc < 20000)}, 32'h1);
    @(negedge clk);
    mon_en = 1'b0;
    chk("sb_drained", 32'(sb.size()), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
